// File: rtl/adder_digit_sequencer.sv
// adder_digit_sequencer: digit-serial add/subtract unit reusing one DIGIT-bit ripple slice.
// Optional OVF/ZERO flag logic is built only when ADDER_SEQ_FLAGS_EN is defined.
module adder_digit_sequencer #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("adder_digit_sequencer: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_nx;
    logic             carry, cout_q;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] a_d, b_d, dsum;
    logic [31:0]      base;
    logic             last;

    assign last      = cnt == CW'(N - 1);
    assign IN_READY  = state == IDLE;
    assign OUT_VALID = state == DONE;
    assign S         = s_q;
    assign COUT      = cout_q;

    // one ripple slice of 1-bit full adders on the current digit, merged into the result
    always_comb begin
        base = 32'(cnt) * DIGIT;
        a_d  = a_q[base +: DIGIT];
        b_d  = b_q[base +: DIGIT];
        c    = '0;
        dsum = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_d[i] ^ b_d[i] ^ c[i];
            c[i + 1] = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
        end
        s_nx = s_q;
        s_nx[base +: DIGIT] = dsum;
    end

    // next-state: accept in IDLE, finish on last digit, release on consumer ready
    always_comb begin
        state_nx = (state == IDLE && IN_VALID)  ? RUN  :
                   (state == RUN  && last)      ? DONE :
                   (state == DONE && OUT_READY) ? IDLE : state;
    end

    // operand capture, digit sequencing, carry chaining and result assembly
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && IN_VALID) begin
                a_q   <= A;
                b_q   <= B ^ {WIDTH{SUB}};
                carry <= SUB;
                cnt   <= '0;
            end else if (state == RUN) begin
                s_q   <= s_nx;
                carry <= c[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) cout_q <= c[DIGIT];
            end
        end
    end

`ifdef ADDER_SEQ_FLAGS_EN
    logic ovf_q, zero_q;

    assign OVF  = ovf_q;
    assign ZERO = zero_q;

    // flags captured with the final digit: MSB carry-in vs carry-out, and zero detect
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
            zero_q <= s_nx == '0;
        end
    end
`else
    assign OVF  = 1'b0;
    assign ZERO = 1'b0;
`endif
endmodule

// File: tb/tb_adder_digit_sequencer.sv
// tb_adder_digit_sequencer: scoreboard bench with a behavioural arithmetic model.
module tb_adder_digit_sequencer;
    localparam int N = 4;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, SUB;
    logic [31:0] A, B;
    logic        IN_READY, OUT_VALID, OUT_READY, COUT, OVF, ZERO;
    logic [31:0] S;

    logic force_mode, force_val, rnd;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have = 0;

    adder_digit_sequencer dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .SUB(SUB), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .S(S), .COUT(COUT), .OVF(OVF), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) begin
        #1;
        rnd = ($urandom % 4) != 0;
    end
    assign OUT_READY = force_mode ? force_val : rnd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub, input int acc);
        exp_t        e;
        longint      sa, sbv, r;
        logic [32:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = sub ? sa - sbv : sa + sbv;
        u   = {1'b0, a} + {1'b0, b};
        e.s    = sub ? a - b : a + b;
        e.cout = sub ? (a >= b) : u[32];
`ifdef ADDER_SEQ_FLAGS_EN
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = e.s == 32'd0;
`else
        e.ovf  = 1'b0;
        e.zero = 1'b0;
`endif
        e.acc = acc;
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int t = 0;
        while (!IN_READY && t < 50) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (!IN_READY) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
            return;
        end
        A = a;
        B = b;
        SUB = sub;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        sb.push_back(model(a, b, sub, cyc));
        IN_VALID = 1'b0;
        A = $urandom;
        B = $urandom;
        SUB = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || have || !IN_READY) && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // monitor: pop expected result when OUT_VALID appears, recheck while held
    always @(negedge CLK) begin
        if (!RESET && OUT_VALID) begin
            if (!have) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h expected=none", S);
                end else begin
                    cur  = sb.pop_front();
                    have = 1;
                    chk("latency", 64'(cyc - cur.acc), 64'(N));
                end
            end
            if (have) begin
                chk("S", 64'(S), 64'(cur.s));
                chk("COUT", 64'(COUT), 64'(cur.cout));
                chk("OVF", 64'(OVF), 64'(cur.ovf));
                chk("ZERO", 64'(ZERO), 64'(cur.zero));
                chk("in_ready_done", 64'(IN_READY), 64'd0);
            end
            if (OUT_READY) have = 0;
        end
    end

    initial begin
        int t;
        RESET = 1'b1;
        IN_VALID = 1'b0;
        A = '0;
        B = '0;
        SUB = 1'b0;
        force_mode = 1'b1;
        force_val = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_COUT", 64'(COUT), 64'd0);
        chk("rst_OVF", 64'(OVF), 64'd0);
        chk("rst_ZERO", 64'(ZERO), 64'd0);
        RESET = 1'b0;
        force_mode = 1'b0;
        @(posedge CLK);
        #1;

        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        issue(32'h0000_0003, 32'h0000_0005, 1'b1);
        issue(32'h0000_0000, 32'h0000_0000, 1'b1);

        drain();
        force_mode = 1'b1;
        force_val = 1'b0;
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        t = 0;
        while (!OUT_VALID && t < 20) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
        repeat (3) begin
            @(posedge CLK);
            #1;
            A = $urandom;
            B = $urandom;
            IN_VALID = ~IN_VALID;
            chk("bp_in_ready", 64'(IN_READY), 64'd0);
            chk("bp_hold_valid", 64'(OUT_VALID), 64'd1);
        end
        IN_VALID = 1'b0;
        force_val = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release_valid", 64'(OUT_VALID), 64'd0);
        chk("bp_release_ready", 64'(IN_READY), 64'd1);
        force_mode = 1'b0;

        drain();
        issue($urandom, $urandom, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
        sb.delete();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        chk("post_rst_model", 64'(sb[$].s), 64'h2345_6789);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom % 6 == 0) ? 32'h7FFF_FFFF : $urandom;
            b = ($urandom % 6 == 0) ? a : $urandom;
            issue(a, b, 1'($urandom));
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
